traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
- Parametrised two-approach intersection controller (main road / side road) and the successor to the single-approach light.
- Drives independent R/G/Y outputs per approach with parametrised phase times and a mandatory all-red clearance.
- A pedestrian/priority request on `pass` shortens side green safely, via yellow, instead of forcing green.
- Adds a night flashing mode; sits at the top of the traffic demo, outputs go straight to the lamp drivers.

Parameters:
- CNT_W, 8: width of the phase counter; every time parameter must be >=1 and <= 2^CNT_W-1.
- MAIN_G, 12: main-road green duration, cycles.
- SIDE_G, 10: side-road green duration, cycles.
- Y_TIME, 5: yellow duration, both approaches, cycles.
- AR_TIME, 2: all-red clearance duration, cycles.
- MIN_SIDE_G, 3: minimum side green before a request may cut it short; must be <= SIDE_G.
- FLASH_HALF, 4: half-period of flashing mode, cycles.

Ports:
- clk  in  1  clock; everything on posedge.
- rst  in  1  synchronous, active-high reset.
- pass  in  1  priority request for main road; synchronous to clk, level; only the rising edge is used.
- flash_en  in  1  request night flashing mode; level.
- main_r / main_g / main_y  out  1 each  main-road lamps.
- side_r / side_g / side_y  out  1 each  side-road lamps.
- phase  out  3  current state code, for debug/verification.

Behaviour:
- State encoding: MAIN_G=0, MAIN_Y=1, ALL_R1=2, SIDE_G=3, SIDE_Y=4, ALL_R2=5, FLASH=6; 7 is unreachable and recovers to ALL_R2.
- Lamp outputs are decoded from the state register only (Moore), with no extra latency beyond the state register:
  - MAIN_G: main G, side R.
  - MAIN_Y: main Y, side R.
  - SIDE_G: main R, side G.
  - SIDE_Y: main R, side Y.
  - ALL_R1 / ALL_R2: both R.
  - FLASH: main_y = blink, side_r = blink, all other lamps 0.
- Exactly one lamp per approach is on in every non-FLASH state; main G/Y and side G/Y are never on simultaneously.
- Reset state: state=ALL_R2, cnt=0, pass_d=0, req=0, blink=1.
  - Outputs during reset: main_r=1, side_r=1, all others 0, phase=5.
- Counter: cleared on every state entry, incremented each cycle while in the state.
  - State X with duration D exits when cnt==D-1, so X is held for exactly D cycles.
- Normal cycle: MAIN_G(MAIN_G) -> MAIN_Y(Y_TIME) -> ALL_R1(AR_TIME) -> SIDE_G(SIDE_G) -> SIDE_Y(Y_TIME) -> ALL_R2(AR_TIME) -> MAIN_G.
  - First MAIN_G after reset release begins AR_TIME cycles after rst deasserts.
- Pass request:
  - pass_d registers pass; the edge is pass & ~pass_d.
  - An edge sets req; req is cleared on entry to MAIN_G.
  - An edge seen while in MAIN_G or MAIN_Y is ignored; req stays 0.
  - In SIDE_G with req=1 (including an edge in the same cycle), exit to SIDE_Y when cnt >= MIN_SIDE_G-1, instead of waiting for SIDE_G-1.
  - If req arrives later than that point, SIDE_G exits on the next cycle.
  - SIDE_Y and ALL_R2 durations are never shortened by a request.
- Flash mode:
  - flash_en is sampled only at the exit cycle of ALL_R1 or ALL_R2; if 1, next state is FLASH (cnt=0, blink=1). No green is ever cut short by flash_en.
  - In FLASH, blink toggles when cnt==FLASH_HALF-1 and cnt clears.
  - At that same toggle point, if flash_en=0, exit to ALL_R2 instead of toggling; normal service then resumes at MAIN_G.
  - pass edges in FLASH are ignored; req is held at 0.
- Simultaneous events:
  - rst has priority over everything.
  - pass edge and a natural SIDE_G expiry in the same cycle: both lead to SIDE_Y, no double action.
  - flash_en at an ALL_R exit takes priority over the normal next state.
- Reset mid-operation (any state, including FLASH): next cycle is ALL_R2 with cnt=0, req=0 and both reds on; the sequence restarts as from power-up.

Test Plan:
- Reset/power-up: hold rst 3 cycles then release, defaults -> both R for 2 cycles, then main_g high 12 cycles, phase 0.
- Full cycle, no inputs: run 36 cycles from the first MAIN_G -> state durations exactly 12/5/2/10/5/2; lamp decode checked every cycle.
- Early termination: pulse pass 1 cycle at SIDE_G cycle 1 -> side_y asserts after the 3rd SIDE_G cycle; next MAIN_G arrives 5+2 cycles later with req cleared.
- Ignored request: pulse pass during MAIN_G cycle 4, and hold pass high for 20 cycles -> durations unchanged, and the held level produces no second edge.
- Flash entry/exit: raise flash_en during SIDE_G -> SIDE_G completes; FLASH entered after ALL_R2; main_y/side_r toggle every 4 cycles.
  - Drop flash_en -> exit at the next toggle point into ALL_R2 (2 cycles), then MAIN_G.
- Reset mid-FLASH and mid-SIDE_Y: assert rst 1 cycle -> next cycle phase=5 with both R on; req=0 even if pass was pending.

Source files
------------

// File: rtl/traffic_light_if.sv
// Signal bundle between the intersection controller and its environment:
// request inputs in, lamp drives and debug state code out.
interface traffic_light_if;
   // No valid/ready pair: pass is a level whose rising edge is the request,
   // flash_en is a plain level, and the lamp outputs are valid every cycle.
   logic       pass;
   logic       flash_en;
   logic       main_r;
   logic       main_g;
   logic       main_y;
   logic       side_r;
   logic       side_g;
   logic       side_y;
   logic [2:0] phase;

   modport master (
      output pass,
      output flash_en,
      input  main_r,
      input  main_g,
      input  main_y,
      input  side_r,
      input  side_g,
      input  side_y,
      input  phase
   );

   modport slave (
      input  pass,
      input  flash_en,
      output main_r,
      output main_g,
      output main_y,
      output side_r,
      output side_g,
      output side_y,
      output phase
   );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-approach (main/side) traffic light controller with all-red clearance,
// early side-green termination on a pass request, and night flashing mode.
module traffic_light_ctrl #(
   parameter int CNT_W      = 8,
   parameter int MAIN_G     = 12,
   parameter int SIDE_G     = 10,
   parameter int Y_TIME     = 5,
   parameter int AR_TIME    = 2,
   parameter int MIN_SIDE_G = 3,
   parameter int FLASH_HALF = 4
) (
   input  logic            clk,
   input  logic            rst,
   traffic_light_if.slave  bus
);

   typedef enum logic [2:0] {
      S_MAIN_G = 3'd0,
      S_MAIN_Y = 3'd1,
      S_ALL_R1 = 3'd2,
      S_SIDE_G = 3'd3,
      S_SIDE_Y = 3'd4,
      S_ALL_R2 = 3'd5,
      S_FLASH  = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] MAIN_G_END   = CNT_W'(MAIN_G - 1);
   localparam logic [CNT_W-1:0] SIDE_G_END   = CNT_W'(SIDE_G - 1);
   localparam logic [CNT_W-1:0] Y_END        = CNT_W'(Y_TIME - 1);
   localparam logic [CNT_W-1:0] AR_END       = CNT_W'(AR_TIME - 1);
   localparam logic [CNT_W-1:0] MIN_SIDE_END = CNT_W'(MIN_SIDE_G - 1);
   localparam logic [CNT_W-1:0] FLASH_END    = CNT_W'(FLASH_HALF - 1);

   // Lamp vector order: {main_r, main_g, main_y, side_r, side_g, side_y}
   localparam logic [5:0] LAMPS_ALL_RED = 6'b100_100;

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             pass_d;
   logic             req;
   logic             req_n;
   logic             blink;
   logic             blink_n;
   logic             pass_edge;
   logic [5:0]       lamp_q;

   function automatic logic [5:0] lamps_of(state_t s, logic b);
      case (s)
         S_MAIN_G: lamps_of = 6'b010_100;
         S_MAIN_Y: lamps_of = 6'b001_100;
         S_SIDE_G: lamps_of = 6'b100_010;
         S_SIDE_Y: lamps_of = 6'b100_001;
         S_FLASH:  lamps_of = {2'b00, b, b, 2'b00};
         default:  lamps_of = LAMPS_ALL_RED;
      endcase
   endfunction

   always_comb begin
      pass_edge = bus.pass & ~pass_d;
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      req_n     = req | pass_edge;
      blink_n   = blink;
      case (state)
         S_MAIN_G: begin
            req_n = 1'b0;
            if (cnt == MAIN_G_END) begin
               state_n = S_MAIN_Y;
               cnt_n   = '0;
            end
         end
         S_MAIN_Y: begin
            req_n = 1'b0;
            if (cnt == Y_END) begin
               state_n = S_ALL_R1;
               cnt_n   = '0;
            end
         end
         S_ALL_R1: begin
            if (cnt == AR_END) begin
               cnt_n = '0;
               if (bus.flash_en) begin
                  state_n = S_FLASH;
                  blink_n = 1'b1;
                  req_n   = 1'b0;
               end else begin
                  state_n = S_SIDE_G;
               end
            end
         end
         S_SIDE_G: begin
            // req_n already folds in an edge arriving this very cycle
            if ((cnt == SIDE_G_END) || (req_n && (cnt >= MIN_SIDE_END))) begin
               state_n = S_SIDE_Y;
               cnt_n   = '0;
            end
         end
         S_SIDE_Y: begin
            if (cnt == Y_END) begin
               state_n = S_ALL_R2;
               cnt_n   = '0;
            end
         end
         S_ALL_R2: begin
            if (cnt == AR_END) begin
               cnt_n = '0;
               req_n = 1'b0;
               if (bus.flash_en) begin
                  state_n = S_FLASH;
                  blink_n = 1'b1;
               end else begin
                  state_n = S_MAIN_G;
               end
            end
         end
         S_FLASH: begin
            req_n = 1'b0;
            if (cnt == FLASH_END) begin
               cnt_n = '0;
               if (bus.flash_en) begin
                  blink_n = ~blink;
               end else begin
                  state_n = S_ALL_R2;
               end
            end
         end
         default: begin
            state_n = S_ALL_R2;
            cnt_n   = '0;
            req_n   = 1'b0;
         end
      endcase
   end

   // Lamps are registered from the next-state decode so they change on the
   // same edge as the state register, with no added latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_ALL_R2;
         cnt    <= '0;
         pass_d <= 1'b0;
         req    <= 1'b0;
         blink  <= 1'b1;
         lamp_q <= LAMPS_ALL_RED;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         pass_d <= bus.pass;
         req    <= req_n;
         blink  <= blink_n;
         lamp_q <= lamps_of(state_n, blink_n);
      end
   end

   assign bus.main_r = lamp_q[5];
   assign bus.main_g = lamp_q[4];
   assign bus.main_y = lamp_q[3];
   assign bus.side_r = lamp_q[2];
   assign bus.side_g = lamp_q[1];
   assign bus.side_y = lamp_q[0];
   assign bus.phase  = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a hand-built per-cycle timeline of
// expected phase/lamp values is queued and checked on every falling edge.
module tb_traffic_light_ctrl;
   localparam int W = 9;

   logic clk = 1'b0;
   logic rst;
   traffic_light_if bus();

   traffic_light_ctrl #(
      .CNT_W(8), .MAIN_G(12), .SIDE_G(10), .Y_TIME(5),
      .AR_TIME(2), .MIN_SIDE_G(3), .FLASH_HALF(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected word: {phase[2:0], main_r, main_g, main_y, side_r, side_g, side_y}
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;
   logic [W-1:0] mon_act;
   int n_checks = 0;
   int n_pass   = 0;
   int entry    = 0;
   int cyc      = 0;

   function automatic logic [W-1:0] exp_vec(input int ph, input logic b);
      case (ph)
         0:       exp_vec = {3'd0, 6'b010_100};
         1:       exp_vec = {3'd1, 6'b001_100};
         2:       exp_vec = {3'd2, 6'b100_100};
         3:       exp_vec = {3'd3, 6'b100_010};
         4:       exp_vec = {3'd4, 6'b100_001};
         5:       exp_vec = {3'd5, 6'b100_100};
         default: exp_vec = {3'd6, 2'b00, b, b, 2'b00};
      endcase
   endfunction

   task automatic push_seg(input int ph, input int n, input logic b = 1'b0);
      repeat (n) exp_q.push_back(exp_vec(ph, b));
   endtask

   // Return just after the posedge that produces timeline entry k.
   task automatic goto(input int k);
      while (cyc < k + 1) begin
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask

   task automatic push_cycle(input int side_len);
      push_seg(0, 12); push_seg(1, 5); push_seg(2, 2);
      push_seg(3, side_len); push_seg(4, 5); push_seg(5, 2);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {bus.phase, bus.main_r, bus.main_g, bus.main_y,
                    bus.side_r, bus.side_g, bus.side_y};
         n_checks++;
         if (mon_act === mon_exp) n_pass++;
         else $display("FAIL lamps entry %0d: got phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                       entry, mon_act[8:6], mon_act[5:0], mon_exp[8:6], mon_exp[5:0]);
         entry++;
      end
   end

   initial begin
      rst          = 1'b1;
      bus.pass     = 1'b0;
      bus.flash_en = 1'b0;

      // entries 0..39: reset, then one undisturbed cycle
      push_seg(5, 4);
      push_cycle(10);
      // 40..68: pass at SIDE_G cycle 1 cuts side green to 3
      push_seg(0, 12); push_seg(1, 5); push_seg(2, 2);
      push_seg(3, 3); push_seg(4, 5); push_seg(5, 2);
      // 69..104: pulse and held pass during MAIN_G have no effect
      push_cycle(10);
      // 105..154: flash requested in SIDE_G, entered after ALL_R2, then left
      push_cycle(10);
      push_seg(6, 4, 1'b1); push_seg(6, 4, 1'b0); push_seg(6, 4, 1'b1);
      push_seg(5, 2);
      // 155..188: reset in SIDE_Y with a request pending
      push_seg(0, 12); push_seg(1, 5); push_seg(2, 2); push_seg(3, 10);
      push_seg(4, 3); push_seg(5, 2);
      // 189..232: flash again, reset mid-FLASH
      push_cycle(10);
      push_seg(6, 4, 1'b1); push_seg(6, 2, 1'b0);
      push_seg(5, 2);
      // 233..268: pass edge coincides with natural SIDE_G expiry
      push_cycle(10);
      // 269..304: late request at SIDE_G cnt 5 exits next cycle
      push_seg(0, 12); push_seg(1, 5); push_seg(2, 2);
      push_seg(3, 6); push_seg(4, 5); push_seg(5, 2);
      push_seg(0, 4);

      goto(2);   rst = 1'b0;
      goto(60);  bus.pass = 1'b1;
      goto(61);  bus.pass = 1'b0;
      goto(73);  bus.pass = 1'b1;
      goto(74);  bus.pass = 1'b0;
      goto(76);  bus.pass = 1'b1;
      goto(96);  bus.pass = 1'b0;
      goto(126); bus.flash_en = 1'b1;
      goto(150); bus.flash_en = 1'b0;
      goto(185); bus.pass = 1'b1;
      goto(186); bus.pass = 1'b0; rst = 1'b1;
      goto(187); rst = 1'b0;
      goto(210); bus.flash_en = 1'b1;
      goto(229); bus.pass = 1'b1;
      goto(230); bus.pass = 1'b0; bus.flash_en = 1'b0; rst = 1'b1;
      goto(231); rst = 1'b0;
      goto(261); bus.pass = 1'b1;
      goto(262); bus.pass = 1'b0;
      goto(293); bus.pass = 1'b1;
      goto(294); bus.pass = 1'b0;

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
